uart_rx_packet_ctrl: RTL and testbench

Sequencing controller sitting directly behind the UART receiver. Consumes its byte-valid strobe and byte, frames bytes into packets (SYNC, LEN, payload, checksum) and streams payload bytes with an index. Flags framing, checksum and inter-byte timeout errors and counts good packets. Feeds the command/register layer above the UART.

---
 rtl/uart_rx_packet_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_rx_packet_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packet_ctrl.sv
// Frames UART bytes into SYNC/LEN/payload/checksum packets, streaming payload with index.
// All outputs registered, 1-clock latency from strobe; no backpressure, upstream strobes are always consumed.
module uart_rx_packet_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 4340
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Payload_Valid,
  output logic [7:0] o_Payload_Byte,
  output logic [7:0] o_Payload_Index,
  output logic       o_Pkt_Done,
  output logic       o_Pkt_Error,
  output logic [1:0] o_Err_Code,
  output logic       o_Busy,
  output logic [7:0] o_Pkt_Count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LEN     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CHECK   = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // The abort decision is taken the cycle the counter would step onto TIMEOUT_CLKS-1,
  // so the error pulse appears TIMEOUT_CLKS-1 clocks after the last accepted byte.
  localparam logic [15:0] TO_TERM = 16'(TIMEOUT_CLKS - 2);
  localparam logic [7:0]  LEN_MAX = 8'(MAX_LEN);

  logic [1:0]  state;
  logic [7:0]  len;
  logic [7:0]  idx;
  logic [7:0]  csum;
  logic [15:0] tcnt;
  logic        timeout;

  // A strobe on the terminal-count cycle suppresses the timeout.
  assign timeout = (state != ST_IDLE) && !i_RX_DV && (tcnt == TO_TERM);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state           <= ST_IDLE;
      len             <= 8'd0;
      idx             <= 8'd0;
      csum            <= 8'd0;
      tcnt            <= 16'd0;
      o_Payload_Valid <= 1'b0;
      o_Payload_Byte  <= 8'd0;
      o_Payload_Index <= 8'd0;
      o_Pkt_Done      <= 1'b0;
      o_Pkt_Error     <= 1'b0;
      o_Err_Code      <= ERR_NONE;
      o_Busy          <= 1'b0;
      o_Pkt_Count     <= 8'd0;
    end else begin
      o_Payload_Valid <= 1'b0;
      o_Pkt_Done      <= 1'b0;
      o_Pkt_Error     <= 1'b0;
      tcnt            <= (state == ST_IDLE || i_RX_DV) ? 16'd0 : tcnt + 16'd1;

      if (timeout) begin
        o_Pkt_Error <= 1'b1;
        o_Err_Code  <= ERR_TIMEOUT;
        o_Busy      <= 1'b0;
        state       <= ST_IDLE;
        tcnt        <= 16'd0;
      end else if (i_RX_DV) begin
        case (state)
          ST_IDLE: begin
            if (i_RX_Byte == SYNC_BYTE) begin
              state  <= ST_LEN;
              o_Busy <= 1'b1;
            end
          end
          ST_LEN: begin
            len  <= i_RX_Byte;
            csum <= i_RX_Byte;
            idx  <= 8'd0;
            if (i_RX_Byte == 8'd0 || i_RX_Byte > LEN_MAX) begin
              o_Pkt_Error <= 1'b1;
              o_Err_Code  <= ERR_LEN;
              o_Busy      <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            o_Payload_Valid <= 1'b1;
            o_Payload_Byte  <= i_RX_Byte;
            o_Payload_Index <= idx;
            csum            <= csum ^ i_RX_Byte;
            idx             <= idx + 8'd1;
            if (idx == len - 8'd1) begin
              state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (i_RX_Byte == csum) begin
              o_Pkt_Done  <= 1'b1;
              o_Err_Code  <= ERR_NONE;
              o_Pkt_Count <= o_Pkt_Count + 8'd1;
            end else begin
              o_Pkt_Error <= 1'b1;
              o_Err_Code  <= ERR_CSUM;
            end
            o_Busy <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Directed bench for uart_rx_packet_ctrl: byte-vector table plus timeout, reset and wrap sequences.
module tb_uart_rx_packet_ctrl;

  localparam int TO = 4340;

  logic       clk;
  logic       rst_n;
  logic       dv;
  logic [7:0] rx;
  logic       p_valid;
  logic [7:0] p_byte;
  logic [7:0] p_index;
  logic       done;
  logic       error;
  logic [1:0] code;
  logic       busy;
  logic [7:0] count;

  uart_rx_packet_ctrl dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
    .i_RX_DV        (dv),
    .i_RX_Byte      (rx),
    .o_Payload_Valid(p_valid),
    .o_Payload_Byte (p_byte),
    .o_Payload_Index(p_index),
    .o_Pkt_Done     (done),
    .o_Pkt_Error    (error),
    .o_Err_Code     (code),
    .o_Busy         (busy),
    .o_Pkt_Count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid, byte, index, done, error, code, busy, count}
  typedef struct packed {
    logic       v;
    logic [7:0] pb;
    logic [7:0] pi;
    logic       d;
    logic       e;
    logic [1:0] c;
    logic       bz;
    logic [7:0] n;
  } obs_t;

  typedef struct packed {
    logic [7:0] b;
    obs_t       exp;
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t vt[$];

  function automatic obs_t get_obs();
    obs_t o;
    o.v = p_valid; o.pb = p_byte; o.pi = p_index; o.d = done;
    o.e = error;   o.c = code;    o.bz = busy;    o.n = count;
    return o;
  endfunction

  function automatic vec_t mk(logic [7:0] b, logic v, logic [7:0] pb, logic [7:0] pi,
                              logic d, logic e, logic [1:0] c, logic bz, logic [7:0] n);
    vec_t r;
    r.b = b;
    r.exp = '{v: v, pb: pb, pi: pi, d: d, e: e, c: c, bz: bz, n: n};
    return r;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got v=%b b=%h i=%h d=%b e=%b c=%b busy=%b n=%h, want v=%b b=%h i=%h d=%b e=%b c=%b busy=%b n=%h",
               name, act.v, act.pb, act.pi, act.d, act.e, act.c, act.bz, act.n,
               exp.v, exp.pb, exp.pi, exp.d, exp.e, exp.c, exp.bz, exp.n);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One-cycle strobe; returns on the following negedge, where the registered response is visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    dv = 1'b1;
    rx = b;
    @(negedge clk);
    dv = 1'b0;
    rx = 8'h00;
  endtask

  initial begin
    obs_t zero;
    int   first_err;
    int   early_err;
    zero  = '0;
    rst_n = 1'b0;
    dv    = 1'b0;
    rx    = 8'h00;

    vt.push_back(mk(8'hA5, 0, 8'h00, 8'h00, 0, 0, 2'd0, 1, 8'd0));
    vt.push_back(mk(8'h03, 0, 8'h00, 8'h00, 0, 0, 2'd0, 1, 8'd0));
    vt.push_back(mk(8'h11, 1, 8'h11, 8'h00, 0, 0, 2'd0, 1, 8'd0));
    vt.push_back(mk(8'h22, 1, 8'h22, 8'h01, 0, 0, 2'd0, 1, 8'd0));
    vt.push_back(mk(8'h33, 1, 8'h33, 8'h02, 0, 0, 2'd0, 1, 8'd0));
    vt.push_back(mk(8'h03, 0, 8'h33, 8'h02, 1, 0, 2'd0, 0, 8'd1));
    vt.push_back(mk(8'hA5, 0, 8'h33, 8'h02, 0, 0, 2'd0, 1, 8'd1));
    vt.push_back(mk(8'h03, 0, 8'h33, 8'h02, 0, 0, 2'd0, 1, 8'd1));
    vt.push_back(mk(8'h11, 1, 8'h11, 8'h00, 0, 0, 2'd0, 1, 8'd1));
    vt.push_back(mk(8'h22, 1, 8'h22, 8'h01, 0, 0, 2'd0, 1, 8'd1));
    vt.push_back(mk(8'h33, 1, 8'h33, 8'h02, 0, 0, 2'd0, 1, 8'd1));
    vt.push_back(mk(8'h04, 0, 8'h33, 8'h02, 0, 1, 2'd2, 0, 8'd1));
    vt.push_back(mk(8'hA5, 0, 8'h33, 8'h02, 0, 0, 2'd2, 1, 8'd1));
    vt.push_back(mk(8'h00, 0, 8'h33, 8'h02, 0, 1, 2'd1, 0, 8'd1));
    vt.push_back(mk(8'hA5, 0, 8'h33, 8'h02, 0, 0, 2'd1, 1, 8'd1));
    vt.push_back(mk(8'h11, 0, 8'h33, 8'h02, 0, 1, 2'd1, 0, 8'd1));
    vt.push_back(mk(8'hA5, 0, 8'h33, 8'h02, 0, 0, 2'd1, 1, 8'd1));
    vt.push_back(mk(8'h01, 0, 8'h33, 8'h02, 0, 0, 2'd1, 1, 8'd1));
    vt.push_back(mk(8'h7E, 1, 8'h7E, 8'h00, 0, 0, 2'd1, 1, 8'd1));
    vt.push_back(mk(8'h7E, 0, 8'h7E, 8'h00, 0, 1, 2'd2, 0, 8'd1)); // 01^7E = 7F, so 7E is bad
    vt.push_back(mk(8'hA5, 0, 8'h7E, 8'h00, 0, 0, 2'd2, 1, 8'd1));
    vt.push_back(mk(8'h01, 0, 8'h7E, 8'h00, 0, 0, 2'd2, 1, 8'd1));
    vt.push_back(mk(8'h7E, 1, 8'h7E, 8'h00, 0, 0, 2'd2, 1, 8'd1));
    vt.push_back(mk(8'h7F, 0, 8'h7E, 8'h00, 1, 0, 2'd0, 0, 8'd2));
    vt.push_back(mk(8'h00, 0, 8'h7E, 8'h00, 0, 0, 2'd0, 0, 8'd2));
    vt.push_back(mk(8'hFF, 0, 8'h7E, 8'h00, 0, 0, 2'd0, 0, 8'd2));
    vt.push_back(mk(8'h5A, 0, 8'h7E, 8'h00, 0, 0, 2'd0, 0, 8'd2));

    #2;
    check("reset_state", get_obs(), zero);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      send(vt[i].b);
      check($sformatf("vec%0d_%h", i, vt[i].b), get_obs(), vt[i].exp);
    end

    // Timeout: error exactly TO-1 clocks after the last accepted strobe.
    send(8'hA5);
    send(8'h02);
    send(8'h11);
    check("to_payload", get_obs(), mk(8'h00, 1, 8'h11, 8'h00, 0, 0, 2'd0, 1, 8'd2).exp);
    first_err = -1;
    for (int k = 1; k <= TO + 10 && first_err < 0; k++) begin
      @(negedge clk);
      if (error) begin
        first_err = k;
        check("to_error_obs", get_obs(), mk(8'h00, 0, 8'h11, 8'h00, 0, 1, 2'd3, 0, 8'd2).exp);
      end
    end
    check_int("to_latency", first_err, TO - 1);

    // Strobe lands on the terminal-count cycle: byte wins.
    send(8'hA5);
    send(8'h02);
    send(8'h11);
    early_err = 0;
    repeat (TO - 2) begin
      @(negedge clk);
      if (error) early_err++;
    end
    dv = 1'b1;
    rx = 8'h22;
    @(negedge clk);
    dv = 1'b0;
    check("tc_byte_wins", get_obs(), mk(8'h00, 1, 8'h22, 8'h01, 0, 0, 2'd3, 1, 8'd2).exp);
    check_int("tc_no_early_err", early_err, 0);
    send(8'h31);
    check("tc_done", get_obs(), mk(8'h00, 0, 8'h22, 8'h01, 1, 0, 2'd0, 0, 8'd3).exp);

    // Reset mid-payload.
    send(8'hA5);
    send(8'h03);
    send(8'h11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midpkt_reset", get_obs(), zero);
    @(negedge clk);
    check("reset_hold", get_obs(), zero);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("after_reset_idle", get_obs(), zero);
    send(8'hA5);
    send(8'h01);
    send(8'hA5);
    check("sync_as_data", get_obs(), mk(8'h00, 1, 8'hA5, 8'h00, 0, 0, 2'd0, 1, 8'd0).exp);
    send(8'hA4);
    check("sync_as_data_done", get_obs(), mk(8'h00, 0, 8'hA5, 8'h00, 1, 0, 2'd0, 0, 8'd1).exp);

    // Count wrap: from a fresh reset, 256 good packets bring the count back to 0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 256; p++) begin
      send(8'hA5);
      send(8'h01);
      send(8'h5C);
      send(8'h5D);
      if (p == 254) check_int("count_255", int'(count), 255);
    end
    check("count_wrap", get_obs(), mk(8'h00, 0, 8'h5C, 8'h00, 1, 0, 2'd0, 0, 8'd0).exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
